data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache placed between the single-cycle CPU's data port and the block-wide data memory. It serves byte reads and writes to the CPU, stalling it through `busywait` on misses. On a miss it writes back a dirty victim block, then fetches the new 4-byte block. The CPU-side ports match the CPU's existing memory interface one-for-one, so the cache drops in without CPU changes.

## Interface
- No parameters; geometry is fixed: 8 blocks × 4 bytes, 8-bit byte address = tag[7:5], index[4:2], offset[1:0].
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- read  in  1  CPU byte-read request, held until `busywait` is sampled low.
- write  in  1  CPU byte-write request, held until `busywait` is sampled low.
- address  in  8  CPU byte address.
- writedata  in  8  CPU write byte.
- readdata  out  8  read byte; valid when `read && !busywait`.
- busywait  out  1  stall to CPU.
- mem_read  out  1  block-fetch request to data memory.
- mem_write  out  1  block write-back request to data memory.
- mem_address  out  6  block address {tag,index}.
- mem_writedata  out  32  victim block, byte 0 in [7:0].
- mem_readdata  in  32  fetched block, byte 0 in [7:0].
- mem_busywait  in  1  memory busy flag.
- Stats ports (only with `DATA_CACHE_STATS_EN`): hit_count  out  16, miss_count  out  16.

## Operation
- Storage per block: valid, dirty, 3-bit tag, 32-bit data.
- hit = valid[index] && tag[index]==address[7:5].
- busywait = (read|write) && !(state==IDLE && hit), combinational.
- readdata = data[index] byte selected by offset, combinational.
- Write hit in IDLE: the byte is written at the posedge; dirty[index] is set.
- If read and write are both asserted, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE → WRITEBACK on miss with valid&&dirty victim. IDLE → FETCH on miss with a clean or invalid victim. IDLE stays on hit or no request.
- WRITEBACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim data. → FETCH on completion.
- FETCH: mem_read=1, mem_address={address[7:5],index}. → UPDATE on completion.
- UPDATE: data[index]←mem_readdata, tag←address[7:5], valid←1, dirty←0. No memory request. → IDLE.
- Back in IDLE, the request hits and completes normally; a write then sets dirty.
- Completion of a memory request: first posedge with mem_busywait==0 after at least one cycle in the state. An internal one-cycle "issued" flag ensures the first cycle never completes.
- Outside WRITEBACK/FETCH: mem_read=mem_write=0, mem_address=0, mem_writedata=0.

## Timing
- Reset values (next posedge with RESET=1): state IDLE, all valid/dirty/tag/data cleared, mem_read=0, mem_write=0, busywait=0 absent requests, stats counters 0.
- RESET during WRITEBACK/FETCH aborts the operation; memory requests drop the cycle after. The partial block is discarded and stays invalid.
- Hit: zero stall cycles; readdata is valid in the same cycle.
- Clean miss, memory latency L cycles (mem_busywait high L−1 cycles after issue): busywait high for L+2 cycles (FETCH L, UPDATE 1, IDLE-hit 0, plus the issue cycle).
- Dirty miss: adds L cycles of WRITEBACK.
- address, read and write must be stable while busywait=1. A change of address mid-miss is undefined; no check is required.
- Index 7 and tag 7 (address 0xFF) use no special case; there is no wrap-around logic.

## Configuration
- `DATA_CACHE_STATS_EN` defined: 16-bit saturating hit_count and miss_count ports are added, each saturating at 0xFFFF.
  - miss_count increments on each IDLE→WRITEBACK/FETCH transition.
  - hit_count increments when a request completes (busywait low) with no preceding miss for that request, tracked by an internal "missed" flag cleared on completion.
- Undefined: the counters, the ports and the flag are absent. Functional behaviour is identical.

## Test plan
- RESET, then read 0x05 with memory latency 5: FETCH block 1 with busywait high 7 cycles, then readdata = byte 1 of mem_readdata; a second read of 0x05 → 0 stall cycles.
- Write 0xAB to 0x06 after the block is resident → no stall; a following read of 0x06 returns 0xAB; dirty[1]=1 with no memory traffic.
- Read 0x26 (tag 1, index 1) with block 1 dirty → WRITEBACK with mem_address=0x01 and mem_writedata containing 0xAB in [23:16], then FETCH mem_address=0x09.
- Write miss to 0x40 (clean victim) → FETCH 0x10, UPDATE, then the byte written and dirty[0]=1; no write-back.
- RESET asserted on the third cycle of FETCH → mem_read=0 next cycle, all blocks invalid; re-reading the same address refetches.
- With `DATA_CACHE_STATS_EN`: 3 hits and 2 misses → hit_count=3, miss_count=2. Preload both counters at 0xFFFF, then one further hit and one further miss → both remain 0xFFFF.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate byte cache.
// 8 blocks x 4 bytes; address = tag[7:5], index[4:2], offset[1:0].
// Optional hit/miss statistics ports are enabled by defining DATA_CACHE_STATS_EN.
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t      state_q;
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];
    logic        issued_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [5:0]  mem_address_q;
    logic [31:0] mem_writedata_q;

    logic [2:0]  req_tag;
    logic [2:0]  req_idx;
    logic [1:0]  req_off;
    logic        req;
    logic        hit;
    logic        mem_done;

    assign req_tag  = address[7:5];
    assign req_idx  = address[4:2];
    assign req_off  = address[1:0];
    assign req      = read | write;
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // The issued flag holds off completion during the first cycle of a request.
    assign mem_done = issued_q && !mem_busywait;

    assign busywait      = req && !(state_q == IDLE && hit);
    assign readdata      = data_q[req_idx][{req_off, 3'b000} +: 8];
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    // Controller FSM with storage update and registered memory-side outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            issued_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    issued_q <= 1'b0;
                    if (req) begin
                        if (hit) begin
                            if (write) begin
                                data_q[req_idx][{req_off, 3'b000} +: 8] <= writedata;
                                dirty_q[req_idx] <= 1'b1;
                            end
                        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q         <= WRITEBACK;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {tag_q[req_idx], req_idx};
                            mem_writedata_q <= data_q[req_idx];
                        end else begin
                            state_q       <= FETCH;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {req_tag, req_idx};
                        end
                    end
                end
                WRITEBACK: begin
                    issued_q <= 1'b1;
                    if (mem_done) begin
                        state_q         <= FETCH;
                        issued_q        <= 1'b0;
                        mem_write_q     <= 1'b0;
                        mem_read_q      <= 1'b1;
                        mem_address_q   <= {req_tag, req_idx};
                        mem_writedata_q <= '0;
                    end
                end
                FETCH: begin
                    issued_q <= 1'b1;
                    if (mem_done) begin
                        state_q       <= UPDATE;
                        issued_q      <= 1'b0;
                        mem_read_q    <= 1'b0;
                        mem_address_q <= '0;
                    end
                end
                UPDATE: begin
                    data_q[req_idx]  <= mem_readdata;
                    tag_q[req_idx]   <= req_tag;
                    valid_q[req_idx] <= 1'b1;
                    dirty_q[req_idx] <= 1'b0;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        missed_q, missed_d;
    logic        complete;
    logic        miss_event;

    assign complete   = req && !busywait;
    assign miss_event = (state_q == IDLE) && req && !hit;

    // Saturating counters; missed marks a request that has already counted as a miss.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        missed_d   = missed_q;
        if (miss_event) begin
            missed_d = 1'b1;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
        if (complete) begin
            missed_d = 1'b0;
            if (!missed_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            missed_q   <= missed_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a
// variable-latency block memory model. Stats checks run with DATA_CACHE_STATS_EN.
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = '0;
    logic [7:0]  writedata = '0;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DATA_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: byte k of block a is {k[1:0], a}; busy for lat-1 cycles after issue.
    int          lat = 5;
    int          cnt = 0;
    logic [31:0] rdata_q = '0;

    function automatic logic [31:0] pat(input logic [5:0] a);
        return {2'b11, a, 2'b10, a, 2'b01, a, 2'b00, a};
    endfunction

    assign mem_busywait = (mem_read || mem_write) && (cnt < lat - 1);
    assign mem_readdata = rdata_q;

    always @(posedge CLK) begin
        cnt <= ((mem_read || mem_write) && mem_busywait) ? cnt + 1 : 0;
        if (mem_read) rdata_q <= pat(mem_address);
    end

    // Per-access observations
    int          stall;
    int          wb_cyc;
    int          rd_cyc;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  fetch_addr;
    logic [7:0]  rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        bit done;
        int guard;
        stall = 0; wb_cyc = 0; rd_cyc = 0;
        wb_addr = '0; wb_data = '0; fetch_addr = '0; rdata = '0;
        read = rd; write = wr; address = a; writedata = wd;
        done = 1'b0;
        guard = 0;
        while (!done && guard < 64) begin
            @(negedge CLK);
            if (mem_write) begin wb_cyc++; wb_addr = mem_address; wb_data = mem_writedata; end
            if (mem_read)  begin rd_cyc++; fetch_addr = mem_address; end
            if (!busywait) begin
                done = 1'b1;
                rdata = readdata;
            end else begin
                stall++;
                guard++;
                @(posedge CLK); #1;
            end
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busywait", busywait, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 6'h00);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        @(posedge CLK); #1;

        // Clean miss, L=5
        lat = 5;
        access(1, 0, 8'h05, 8'h00);
        chk("miss05_stall", stall, 7);
        chk("miss05_fetch_cyc", rd_cyc, 5);
        chk("miss05_fetch_addr", fetch_addr, 6'h01);
        chk("miss05_no_wb", wb_cyc, 0);
        chk("miss05_rdata", rdata, 8'h41);
        access(1, 0, 8'h05, 8'h00);
        chk("hit05_stall", stall, 0);
        chk("hit05_rdata", rdata, 8'h41);
        access(1, 0, 8'h07, 8'h00);
        chk("hit07_rdata", rdata, 8'hC1);

        // Write hit, then read back
        access(0, 1, 8'h06, 8'hAB);
        chk("wr06_stall", stall, 0);
        chk("wr06_traffic", wb_cyc + rd_cyc, 0);
        access(1, 0, 8'h06, 8'h00);
        chk("rd06_rdata", rdata, 8'hAB);
        chk("rd06_stall", stall, 0);

        // Dirty miss on index 1
        access(1, 0, 8'h26, 8'h00);
        chk("miss26_stall", stall, 12);
        chk("miss26_wb_cyc", wb_cyc, 5);
        chk("miss26_wb_addr", wb_addr, 6'h01);
        chk("miss26_wb_data", wb_data, 32'hC1AB4101);
        chk("miss26_fetch_addr", fetch_addr, 6'h09);
        chk("miss26_rdata", rdata, 8'h89);

        // Write miss with clean victim, L=2
        lat = 2;
        access(0, 1, 8'h40, 8'h5A);
        chk("wmiss40_stall", stall, 4);
        chk("wmiss40_no_wb", wb_cyc, 0);
        chk("wmiss40_fetch_addr", fetch_addr, 6'h10);
        access(1, 0, 8'h40, 8'h00);
        chk("rd40_rdata", rdata, 8'h5A);
        access(1, 0, 8'h41, 8'h00);
        chk("rd41_rdata", rdata, 8'h50);

        // Evicting the written block proves dirty[0] was set
        access(1, 0, 8'h00, 8'h00);
        chk("miss00_stall", stall, 6);
        chk("miss00_wb_addr", wb_addr, 6'h10);
        chk("miss00_wb_data", wb_data, 32'hD090505A);
        chk("miss00_fetch_addr", fetch_addr, 6'h00);
        chk("miss00_rdata", rdata, 8'h00);

        // read and write together act as a write; address 0xFF boundary
        access(1, 1, 8'hFF, 8'h77);
        chk("rwFF_stall", stall, 4);
        chk("rwFF_fetch_addr", fetch_addr, 6'h3F);
        access(1, 0, 8'hFF, 8'h00);
        chk("rdFF_rdata", rdata, 8'h77);
        access(1, 0, 8'hFE, 8'h00);
        chk("rdFE_rdata", rdata, 8'hBF);

        // Reset during the third FETCH cycle
        lat = 5;
        read = 1'b1; address = 8'h05;
        @(negedge CLK);
        chk("rstf_issue_busy", busywait, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1; read = 1'b0;
        @(negedge CLK);
        chk("rstf_mem_read_before", mem_read, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rstf_mem_read_after", mem_read, 1'b0);
        chk("rstf_busywait", busywait, 1'b0);
        @(posedge CLK); #1;
        access(1, 0, 8'h05, 8'h00);
        chk("rstf_refetch_stall", stall, 7);
        chk("rstf_refetch_addr", fetch_addr, 6'h01);
        chk("rstf_refetch_rdata", rdata, 8'h41);
        access(1, 0, 8'h40, 8'h00);
        chk("rstf_blk0_stall", stall, 7);
        chk("rstf_blk0_no_wb", wb_cyc, 0);
        chk("rstf_blk0_rdata", rdata, 8'h10);

`ifdef DATA_CACHE_STATS_EN
        // Since the reset: two misses so far, now three hits
        access(1, 0, 8'h05, 8'h00);
        access(1, 0, 8'h40, 8'h00);
        access(1, 0, 8'h06, 8'h00);
        @(negedge CLK);
        chk("stats_hits", hit_count, 16'd3);
        chk("stats_misses", miss_count, 16'd2);
        @(posedge CLK); #1;
        force dut.hit_cnt_q = 16'hFFFF;
        force dut.miss_cnt_q = 16'hFFFF;
        @(posedge CLK); #1;
        release dut.hit_cnt_q;
        release dut.miss_cnt_q;
        access(1, 0, 8'h05, 8'h00);
        access(1, 0, 8'hA0, 8'h00);
        @(negedge CLK);
        chk("stats_hit_sat", hit_count, 16'hFFFF);
        chk("stats_miss_sat", miss_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
